// File: rtl/switch_allocator.sv
// ----------------------------------------------------------------------------
// switch_allocator
//
// Purpose:
//   Output-side switch allocator for a wormhole router. Every output port is
//   arbitrated independently among the input ports whose head-of-buffer flit
//   is routed to it. An output that grants a HEAD flit stays reserved for that
//   input until the packet's TAIL is granted. Fresh packets are chosen
//   round-robin, and the pointer advances only when a packet completes.
//   Grants are combinational, with zero-cycle latency. Lock, owner and
//   round-robin state update on the next rising clock edge.
//
// Parameters:
//   PORT_NUM     number of router ports (inputs = outputs), >= 2
//   STATS_WIDTH  width of each per-output grant counter
//
// Encodings:
//   port_t       $clog2(PORT_NUM) bits. Values >= PORT_NUM address no output.
//   flit_label_t 2 bits: 0 = HEAD, 1 = BODY, 2 = TAIL, 3 = HEADTAIL
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst            synchronous, active-high reset
//   request_i      [PORT_NUM]          per input: switch request
//   out_port_i     [PORT_NUM*port_t]   per input: routed output of head flit
//   flit_label_i   [PORT_NUM*2]        per input: label of head flit
//   on_off_i       [PORT_NUM]          per output: downstream can accept
//   grant_o        [PORT_NUM]          per input: flit read/forward grant
//   xb_sel_o       [PORT_NUM*port_t]   per output: crossbar input select
//   xb_valid_o     [PORT_NUM]          per output: crossbar carries a flit
//   locked_o       [PORT_NUM]          per output: registered lock state
//   grant_count_o  [PORT_NUM*STATS_WIDTH] per output: wrapping grant count
//                                      (present only with SA_GRANT_STATS_EN)
//
// Build option:
//   `define SA_GRANT_STATS_EN to add the per-output grant counters and the
//   grant_count_o port. Without it, the counters and the port do not exist.
// ----------------------------------------------------------------------------
module switch_allocator #(
    parameter int unsigned  PORT_NUM    = 5,
    parameter int unsigned  STATS_WIDTH = 16,
    localparam int unsigned PW          = $clog2(PORT_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORT_NUM-1:0]    request_i,
    input  logic [PORT_NUM*PW-1:0] out_port_i,
    input  logic [PORT_NUM*2-1:0]  flit_label_i,
    input  logic [PORT_NUM-1:0]    on_off_i,
    output logic [PORT_NUM-1:0]    grant_o,
    output logic [PORT_NUM*PW-1:0] xb_sel_o,
    output logic [PORT_NUM-1:0]    xb_valid_o,
    output logic [PORT_NUM-1:0]    locked_o
`ifdef SA_GRANT_STATS_EN
    ,
    output logic [PORT_NUM*STATS_WIDTH-1:0] grant_count_o
`endif
);

    // Degenerate configurations are rejected at elaboration time.
    if (PORT_NUM < 2 || STATS_WIDTH < 1) begin : g_bad_cfg
        $error("switch_allocator: PORT_NUM must be >= 2 and STATS_WIDTH >= 1");
    end

    localparam logic [1:0] LblHead     = 2'd0;
    localparam logic [1:0] LblBody     = 2'd1;
    localparam logic [1:0] LblTail     = 2'd2;
    localparam logic [1:0] LblHeadTail = 2'd3;

    typedef enum logic {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } lock_state_e;

    // Per-output registered state and its next-state values.
    lock_state_e   r_state   [PORT_NUM];
    lock_state_e   w_state_d [PORT_NUM];
    logic [PW-1:0] r_owner   [PORT_NUM];
    logic [PW-1:0] w_owner_d [PORT_NUM];
    logic [PW-1:0] r_rr_ptr  [PORT_NUM];
    logic [PW-1:0] w_rr_d    [PORT_NUM];

    // Unpacked per-input fields.
    logic [PW-1:0]       w_dest    [PORT_NUM];
    logic [1:0]          w_label   [PORT_NUM];
    logic [PORT_NUM-1:0] w_head_ok;

    // w_cand[o][i]: input i is requesting output o.
    logic [PORT_NUM-1:0] w_cand [PORT_NUM];

    // Per-output arbitration result.
    logic [PORT_NUM-1:0] w_win_vld;
    logic [PW-1:0]       w_win [PORT_NUM];

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            w_dest[i]    = out_port_i[i*PW +: PW];
            w_label[i]   = flit_label_i[i*2 +: 2];
            w_head_ok[i] = (w_label[i] == LblHead) || (w_label[i] == LblHeadTail);
        end
    end

    // A destination at or above PORT_NUM never equals a valid output index,
    // so that request never becomes a candidate.
    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                w_cand[o][i] = request_i[i] && (w_dest[i] == PW'(o));
            end
        end
    end

    // Arbitration. A locked output serves only its owner. An unlocked output
    // takes the first head-capable candidate at or after rr_ptr, searching
    // cyclically.
    always_comb begin
        int unsigned   idx;
        logic [PW-1:0] sel;
        idx       = 0;
        sel       = '0;
        w_win_vld = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            w_win[o] = '0;
            if (!rst && on_off_i[o]) begin
                if (r_state[o] == StLocked) begin
                    w_win_vld[o] = w_cand[o][r_owner[o]];
                    w_win[o]     = r_owner[o];
                end else begin
                    for (int unsigned k = 0; k < PORT_NUM; k++) begin
                        idx = 32'(r_rr_ptr[o]) + k;
                        if (idx >= PORT_NUM) begin
                            idx = idx - PORT_NUM;
                        end
                        sel = PW'(idx);
                        if (!w_win_vld[o] && w_cand[o][sel] && w_head_ok[sel]) begin
                            w_win_vld[o] = 1'b1;
                            w_win[o]     = sel;
                        end
                    end
                end
            end
        end
    end

    // Lock FSM: next state from the label of the flit that won this cycle.
    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            w_state_d[o] = r_state[o];
            w_owner_d[o] = r_owner[o];
            w_rr_d[o]    = r_rr_ptr[o];
            if (w_win_vld[o]) begin
                unique case (w_label[w_win[o]])
                    LblHead: begin
                        w_state_d[o] = StLocked;
                        w_owner_d[o] = w_win[o];
                    end
                    LblBody: begin
                    end
                    LblTail, LblHeadTail: begin
                        // Packet done. Release the output and give priority to
                        // the input after the one just served.
                        w_state_d[o] = StUnlocked;
                        w_owner_d[o] = '0;
                        w_rr_d[o]    = (w_win[o] == PW'(PORT_NUM - 1)) ? '0 : w_win[o] + 1'b1;
                    end
                endcase
            end
        end
    end

    // Lock FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                r_state[o]  <= StUnlocked;
                r_owner[o]  <= '0;
                r_rr_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                r_state[o]  <= w_state_d[o];
                r_owner[o]  <= w_owner_d[o];
                r_rr_ptr[o] <= w_rr_d[o];
            end
        end
    end

    // Outputs. An idle crossbar leg selects the owner while the output is
    // locked and input 0 otherwise.
    always_comb begin
        grant_o    = '0;
        xb_sel_o   = '0;
        xb_valid_o = '0;
        locked_o   = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            locked_o[o]   = (r_state[o] == StLocked);
            xb_valid_o[o] = w_win_vld[o];
            if (w_win_vld[o]) begin
                grant_o[w_win[o]]    = 1'b1;
                xb_sel_o[o*PW +: PW] = w_win[o];
            end else if (r_state[o] == StLocked) begin
                xb_sel_o[o*PW +: PW] = r_owner[o];
            end
        end
    end

`ifdef SA_GRANT_STATS_EN
    // Per-output grant counters; they wrap silently.
    logic [STATS_WIDTH-1:0] r_grant_cnt [PORT_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                r_grant_cnt[o] <= '0;
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (xb_valid_o[o]) begin
                    r_grant_cnt[o] <= r_grant_cnt[o] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_count_o = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            grant_count_o[o*STATS_WIDTH +: STATS_WIDTH] = r_grant_cnt[o];
        end
    end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
`timescale 1ns/1ps
module tb_switch_allocator;
    localparam int N  = 5;
    localparam int PW = 3;
`ifdef SA_GRANT_STATS_EN
    localparam int SW = 4;
`else
    localparam int SW = 16;
`endif
    localparam int L_HEAD = 0;
    localparam int L_BODY = 1;
    localparam int L_TAIL = 2;
    localparam int L_HT   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  request;
    logic [N*PW-1:0] out_port;
    logic [N*2-1:0]  label;
    logic [N-1:0]  on_off;
    logic [N-1:0]  grant;
    logic [N*PW-1:0] xb_sel;
    logic [N-1:0]  xb_valid;
    logic [N-1:0]  locked;
`ifdef SA_GRANT_STATS_EN
    logic [N*SW-1:0] grant_count;
`endif

    switch_allocator #(.PORT_NUM(N), .STATS_WIDTH(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .request_i    (request),
        .out_port_i   (out_port),
        .flit_label_i (label),
        .on_off_i     (on_off),
        .grant_o      (grant),
        .xb_sel_o     (xb_sel),
        .xb_valid_o   (xb_valid),
        .locked_o     (locked)
`ifdef SA_GRANT_STATS_EN
        ,
        .grant_count_o(grant_count)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: per-output lock/owner/pointer/count, updated from rules.
    bit   m_locked [N];
    int   m_owner  [N];
    int   m_rr     [N];
    int   m_cnt    [N];
    bit   cmp_on;
    logic [N-1:0] last_grant;

    function automatic int dest_of(input int i);
        return int'(out_port[i*PW +: PW]);
    endfunction

    function automatic int lbl_of(input int i);
        return int'(label[i*2 +: 2]);
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            logic [N-1:0]    eg;
            logic [N-1:0]    ev;
            logic [N-1:0]    el;
            logic [N*PW-1:0] es;
            int win [N];
            int i;
            eg = '0;
            ev = '0;
            el = '0;
            es = '0;
            for (int o = 0; o < N; o++) begin
                win[o] = -1;
                if (!rst && on_off[o]) begin
                    if (m_locked[o]) begin
                        if (request[m_owner[o]] && dest_of(m_owner[o]) == o) win[o] = m_owner[o];
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            i = (m_rr[o] + k) % N;
                            if (win[o] < 0 && request[i] && dest_of(i) == o &&
                                (lbl_of(i) == L_HEAD || lbl_of(i) == L_HT)) win[o] = i;
                        end
                    end
                end
                el[o] = m_locked[o];
                if (win[o] >= 0) begin
                    ev[o] = 1'b1;
                    eg[win[o]] = 1'b1;
                    es[o*PW +: PW] = PW'(win[o]);
                end else if (m_locked[o]) begin
                    es[o*PW +: PW] = PW'(m_owner[o]);
                end
            end
            chk("grant_o", grant, eg);
            chk("xb_valid_o", xb_valid, ev);
            chk("xb_sel_o", xb_sel, es);
            chk("locked_o", locked, el);
`ifdef SA_GRANT_STATS_EN
            for (int o = 0; o < N; o++) chk("grant_count_o", grant_count[o*SW +: SW], m_cnt[o]);
`endif
            last_grant = eg;
            for (int o = 0; o < N; o++) begin
                if (rst) begin
                    m_locked[o] = 0; m_owner[o] = 0; m_rr[o] = 0; m_cnt[o] = 0;
                end else if (win[o] >= 0) begin
                    m_cnt[o] = (m_cnt[o] + 1) % (1 << SW);
                    case (lbl_of(win[o]))
                        L_HEAD: begin m_locked[o] = 1; m_owner[o] = win[o]; end
                        L_BODY: ;
                        default: begin
                            m_locked[o] = 0; m_owner[o] = 0; m_rr[o] = (win[o] + 1) % N;
                        end
                    endcase
                end
            end
        end
    end

    task automatic set_in(input int i, input bit req, input int dest, input int lbl);
        request[i]           = req;
        out_port[i*PW +: PW] = PW'(dest);
        label[i*2 +: 2]      = 2'(lbl);
    endtask

    task automatic clear_in();
        request  = '0;
        out_port = '0;
        label    = '0;
        on_off   = '1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Random packet generators, one per input.
    bit g_pkt   [N];
    bit g_fresh [N];
    int g_body  [N];
    int b_dest  [N];
    int b_lbl   [N];
    bit b_req   [N];

    initial begin
        bit prev_rst;
        int r;
        rst    = 1'b1;
        cmp_on = 1'b0;
        last_grant = '0;
        clear_in();
        for (int o = 0; o < N; o++) begin
            m_locked[o] = 0; m_owner[o] = 0; m_rr[o] = 0; m_cnt[o] = 0;
        end
        tick();
        cmp_on = 1'b1;

        // Reset masks grants combinationally.
        for (int i = 0; i < N; i++) set_in(i, 1'b1, (i + 1) % N, L_HEAD);
        mid(); chk("rst_grant", grant, 0); chk("rst_valid", xb_valid, 0);
        tick(); rst = 1'b0; clear_in();
        mid(); chk("reset_locked", locked, 0); chk("reset_sel", xb_sel, 0);
        tick();

        // Round robin between two HEADTAIL requesters on output 2.
        set_in(1, 1'b1, 2, L_HT); set_in(3, 1'b1, 2, L_HT);
        mid(); chk("rr_c0_grant", grant, 5'b00010); chk("rr_c0_sel2", xb_sel[2*PW +: PW], 1);
        tick(); set_in(1, 1'b0, 0, L_HEAD);
        mid(); chk("rr_c1_grant", grant, 5'b01000); chk("rr_model_ptr2", m_rr[2], 4);
        tick(); clear_in();

        // Packet lock on output 4 blocks a competing HEAD until TAIL.
        set_in(0, 1'b1, 4, L_HEAD);
        mid(); chk("lock_head_grant", grant, 5'b00001);
        tick(); set_in(0, 1'b1, 4, L_BODY); set_in(2, 1'b1, 4, L_HEAD);
        mid(); chk("lock_body1_grant", grant, 5'b00001); chk("lock_locked4", locked[4], 1);
        tick();
        mid(); chk("lock_body2_grant", grant, 5'b00001);
        tick(); set_in(0, 1'b1, 4, L_TAIL);
        mid(); chk("lock_tail_grant", grant, 5'b00001);
        tick(); set_in(0, 1'b0, 0, L_HEAD);
        mid(); chk("lock_next_grant", grant, 5'b00100); chk("lock_free4", locked[4], 0);

        // Backpressure on locked output 4.
        tick(); set_in(2, 1'b1, 4, L_BODY); on_off[4] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid(); chk("bp_grant", grant, 0); chk("bp_valid4", xb_valid[4], 0);
            chk("bp_locked4", locked[4], 1);
            tick();
        end
        on_off[4] = 1'b1;
        mid(); chk("bp_resume_grant", grant, 5'b00100);
        tick(); set_in(2, 1'b1, 4, L_TAIL);
        mid(); chk("bp_tail_grant", grant, 5'b00100);
        tick(); clear_in();
        mid(); chk("bp_unlocked", locked, 0);
        tick();

        // All five inputs to distinct outputs in one cycle.
        for (int i = 0; i < N; i++) set_in(i, 1'b1, (i + 1) % N, L_HEAD);
        mid(); chk("all_head_grant", grant, 5'b11111);
        tick(); clear_in();
        mid(); chk("all_locked", locked, 5'b11111);
        tick();
        for (int i = 0; i < N; i++) set_in(i, 1'b1, (i + 1) % N, L_TAIL);
        mid(); chk("all_tail_grant", grant, 5'b11111);
        tick(); clear_in();
        mid(); chk("all_unlocked", locked, 0);
        tick();

        // Reset mid-packet drops the lock; orphan BODY is ignored.
        set_in(3, 1'b1, 1, L_HEAD);
        mid(); chk("rstpkt_head", grant, 5'b01000);
        tick(); set_in(3, 1'b1, 1, L_BODY);
        mid(); chk("rstpkt_locked1", locked[1], 1);
        tick(); rst = 1'b1;
        mid(); chk("rstpkt_rst_grant", grant, 0);
        tick(); rst = 1'b0;
        mid(); chk("rstpkt_unlocked1", locked[1], 0); chk("rstpkt_body_grant", grant, 0);
        tick(); set_in(3, 1'b1, 1, L_HT);
        mid(); chk("rstpkt_ht_grant", grant, 5'b01000);
        tick(); clear_in();

`ifdef SA_GRANT_STATS_EN
        rst = 1'b1;
        tick(); rst = 1'b0;
        set_in(0, 1'b1, 0, L_HT);
        for (int c = 0; c < 17; c++) tick();
        clear_in();
        mid(); chk("stats_wrap_cnt0", grant_count[0 +: SW], 1);
        tick();
`endif

        // Randomised packet traffic.
        rst = 1'b1;
        tick(); rst = 1'b0;
        prev_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            g_pkt[i] = 0; g_fresh[i] = 1; g_body[i] = 0;
            b_dest[i] = 0; b_lbl[i] = L_HEAD; b_req[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (prev_rst) begin
                    g_pkt[i] = 0; g_fresh[i] = 1;
                end else if (last_grant[i]) begin
                    case (b_lbl[i])
                        L_HEAD: begin g_pkt[i] = 1; g_body[i] = $urandom_range(0, 3); end
                        L_BODY: g_body[i]--;
                        default: begin g_pkt[i] = 0; g_fresh[i] = 1; end
                    endcase
                end
                if (g_pkt[i]) begin
                    b_lbl[i] = (g_body[i] > 0) ? L_BODY : L_TAIL;
                    b_req[i] = ($urandom_range(0, 9) < 7);
                end else if (g_fresh[i] || $urandom_range(0, 2) == 0) begin
                    g_fresh[i] = 0;
                    b_dest[i]  = $urandom_range(0, 6);
                    r = $urandom_range(0, 19);
                    b_lbl[i] = (r < 10) ? L_HEAD : (r < 18) ? L_HT : (r == 18) ? L_BODY : L_TAIL;
                    b_req[i] = ($urandom_range(0, 3) != 0);
                end
                set_in(i, b_req[i], b_dest[i], b_lbl[i]);
            end
            for (int o = 0; o < N; o++) on_off[o] = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 399) == 0);
            prev_rst = rst;
            tick();
        end
        rst = 1'b0;
        clear_in();
        tick();
        tick();
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter PORT_NUM, default 5, number of router ports (input ports = output ports), indices follow port_t encoding.
REQ-002 Parameter STATS_WIDTH, default 16, width of each per-output grant counter (Configuration only).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 request_i  input  PORT_NUM  per input port: switch request (driven from input port sa_request_o).
REQ-006 out_port_i  input  PORT_NUM x port_t  per input port: routed output port of head-of-buffer flit.
REQ-007 flit_label_i  input  PORT_NUM x flit_label_t  per input port: label (HEAD/BODY/TAIL/HEADTAIL) of head-of-buffer flit.
REQ-008 on_off_i  input  PORT_NUM  per output port: 1 = downstream can accept a flit this cycle.
REQ-009 grant_o  output  PORT_NUM  per input port: flit read/forward grant (drives input port sa_valid_i).
REQ-010 xb_sel_o  output  PORT_NUM x port_t  per output port: index of input port routed through crossbar.
REQ-011 xb_valid_o  output  PORT_NUM  per output port: crossbar output carries a valid flit this cycle.
REQ-012 locked_o  output  PORT_NUM  per output port: output currently reserved by an in-flight packet.

Function
REQ-013 Candidates for output o: every input i with request_i[i]=1 and out_port_i[i]=o; out_port_i values >= PORT_NUM never match.
REQ-014 Grants are combinational from current inputs and registered state (zero-cycle latency); state updates at next rising edge.
REQ-015 Each output has state UNLOCKED or LOCKED(owner); reset state UNLOCKED, owner 0, rr_ptr 0.
REQ-016 UNLOCKED, on_off_i[o]=1: grant first candidate with label HEAD or HEADTAIL searching cyclically from rr_ptr[o]; BODY/TAIL candidates ignored.
REQ-017 LOCKED(owner), on_off_i[o]=1: grant only owner if it is a candidate; all other candidates blocked.
REQ-018 on_off_i[o]=0: no grant to o; lock, owner, rr_ptr unchanged.
REQ-019 Granted HEAD: UNLOCKED -> LOCKED(i) next cycle; granted BODY: state held; granted TAIL: LOCKED -> UNLOCKED; granted HEADTAIL: stays UNLOCKED.
REQ-020 rr_ptr[o] <= (i+1) mod PORT_NUM only on granted TAIL or HEADTAIL (packet completion); unchanged otherwise.
REQ-021 Owner not requesting while LOCKED: no grant, lock held indefinitely (no timeout).
REQ-022 grant_o[i]=1 iff input i granted by its out_port_i[i]; at most one grant per output, at most one per input.
REQ-023 xb_valid_o[o]=1 iff output o granted this cycle; xb_sel_o[o] = granted input, else holds owner (LOCKED) or 0 (UNLOCKED).
REQ-024 locked_o[o] reflects registered LOCKED state (not next state).

Reset
REQ-025 While rst=1: grant_o, xb_valid_o = 0 combinationally; at the edge all outputs UNLOCKED, owners 0, rr_ptr 0, counters 0.
REQ-026 rst mid-packet drops lock; afterwards BODY/TAIL of that packet are not granted until a HEAD arrives.

Configuration
REQ-027 Macro SA_GRANT_STATS_EN: when defined, output grant_count_o (PORT_NUM x STATS_WIDTH) exists, incremented per cycle xb_valid_o[o]=1, wraps modulo 2^STATS_WIDTH, reset to 0.
REQ-028 Without SA_GRANT_STATS_EN: port and counters absent; all other behaviour identical.

Verification
REQ-029 Inputs 1,3 request out 2 HEADTAIL, rr_ptr[2]=0, on=1 -> cycle0 grant_o=5'b00010, xb_sel_o[2]=1; cycle1 grant_o=5'b01000; rr_ptr[2]=4.
REQ-030 Input 0 HEAD to out 4, then input 2 HEAD to out 4 during BODY flits -> input 2 blocked until input 0 TAIL granted; input 2 granted next cycle.
REQ-031 Owner locked, on_off_i[4]=0 for 3 cycles -> grant_o=0, xb_valid_o[4]=0, locked_o[4]=1 held; resumes when on=1.
REQ-032 Inputs 0..4 each request distinct outputs HEAD -> grant_o=5'b11111 same cycle, all five outputs locked next cycle.
REQ-033 rst asserted while out 1 locked -> locked_o[1]=0 after edge; subsequent BODY request to out 1 -> no grant.
REQ-034 SA_GRANT_STATS_EN, STATS_WIDTH=4: 17 grants on out 0 -> grant_count_o[0]=1.
